// File: rtl/seg7_to_digit.sv
// Debounces a sampled 7-segment pattern, decodes each newly accepted pattern and queues it in a 4-deep FIFO.
// Define SEG7_HEX_EN to also decode the hex letters A..F.
`timescale 1ns/1ps
module seg7_to_digit #(
  parameter int unsigned STABLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  localparam logic [3:0] CNT_LAST = 4'(STABLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [6:0] s_q;
  logic [6:0] last_seen, last_seen_nxt;
  logic       seen_vld;
  logic [6:0] last_acc;
  logic       acc_vld;
  logic       same, accept, push_req, push_ok, pop, full;

  logic [4:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic [4:0] head;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h10;
    case (p)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
`ifdef SEG7_HEX_EN
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
`endif
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // last_seen is meaningless until the first post-reset cycle, so any sample counts as a change then.
  assign same = seen_vld && (s_q == last_seen);

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_seen_nxt = last_seen;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (!same) begin
          state_nxt     = COUNT;
          cnt_nxt       = 4'd1;
          last_seen_nxt = s_q;
        end
      end
      COUNT: begin
        if (!same) begin
          cnt_nxt       = 4'd1;
          last_seen_nxt = s_q;
        end else if (cnt == CNT_LAST) begin
          accept    = 1'b1;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HELD: begin
        if (!same) begin
          state_nxt     = COUNT;
          cnt_nxt       = 4'd1;
          last_seen_nxt = s_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_req  = accept && (!acc_vld || (last_acc != s_q));
  assign out_valid = (count != 3'd0);
  assign full      = (count == 3'd4);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push_req && (!full || pop);
  assign head      = mem[rd_ptr];
  assign out_digit = out_valid ? head[3:0] : 4'h0;
  assign out_err   = out_valid && head[4];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      state     <= IDLE;
      cnt       <= '0;
      last_seen <= '0;
      seen_vld  <= 1'b0;
      last_acc  <= '0;
      acc_vld   <= 1'b0;
    end else begin
      s_q       <= seg;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_seen <= last_seen_nxt;
      seen_vld  <= 1'b1;
      if (accept) begin
        last_acc <= s_q;
        acc_vld  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) ovf <= 1'b1;
    end
  end

  // NOTE: storage needs no reset; emptiness is tracked by count and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= decode(s_q);
  end

endmodule

// File: tb/tb_seg7_to_digit.sv
// Scoreboard bench for seg7_to_digit: expected entries are queued with the stimulus and popped on each handshake.
`timescale 1ns/1ps
module tb_seg7_to_digit;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic       ovf;

  int n_vec = 0;
  int n_bad = 0;

  logic [4:0] exp_q [$];
  logic [4:0] mon_exp;
  logic [6:0] seg_tab [10];
  logic [6:0] seg_hex_a;
  logic [4:0] exp_hex_a;

  int first_k;
  int vcnt;

  seg7_to_digit #(.STABLE(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_digit (out_digit),
    .out_err   (out_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake monitor: the entry visible at the negedge is the one taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_entry", 32'(out_valid), 32'(1'b0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("entry", 32'({out_err, out_digit}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    seg_hex_a = 7'b1110111;
`ifdef SEG7_HEX_EN
    exp_hex_a = 5'h0A;
`else
    exp_hex_a = 5'h10;
`endif

    // Reset state, then the pattern present during reset is accepted once.
    rst_n     = 1'b0;
    seg       = seg_tab[0];
    out_ready = 1'b1;
    tick(3);
    check("rst_valid", 32'(out_valid), 32'(1'b0));
    check("rst_digit", 32'(out_digit), 32'(4'h0));
    check("rst_err",   32'(out_err),   32'(1'b0));
    check("rst_ovf",   32'(ovf),       32'(1'b0));
    exp_q.push_back(5'h00);
    rst_n = 1'b1;
    tick(10);

    // Stable 2: latency STABLE+1 and a single valid cycle with ready high.
    exp_q.push_back(5'h02);
    seg     = seg_tab[2];
    first_k = 0;
    vcnt    = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (out_valid) begin
        vcnt++;
        if (first_k == 0) first_k = k;
      end
    end
    check("lat_2",        32'(first_k), 32'(STABLE + 1));
    check("valid_cyc_2",  32'(vcnt),    32'(1));

    // Unstable 3 rejected, following 1 reported.
    exp_q.push_back(5'h01);
    seg = seg_tab[3];
    tick(3);
    seg = seg_tab[1];
    tick(8);

    // 8, glitch, 8 again: duplicate suppressed.
    exp_q.push_back(5'h08);
    seg = seg_tab[8];
    tick(10);
    seg = 7'b0000001;
    tick(1);
    seg = seg_tab[8];
    tick(10);

    // Hex letter A.
    exp_q.push_back(exp_hex_a);
    seg = seg_hex_a;
    tick(10);

    // Fill the FIFO with ready low.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(5'(i));
      seg = seg_tab[i];
      tick(8);
    end
    check("full_no_ovf", 32'(ovf),       32'(1'b0));
    check("full_valid",  32'(out_valid), 32'(1'b1));
    check("head_hold",   32'(out_digit), 32'(4'h0));

    // Push and pop on the same edge with the FIFO full.
    exp_q.push_back(5'h04);
    seg = seg_tab[4];
    tick(4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("simul_ovf",  32'(ovf),       32'(1'b0));
    check("simul_head", 32'(out_digit), 32'(4'h1));

    // Push into a full FIFO without pop: dropped, ovf sticky.
    seg = seg_tab[5];
    tick(8);
    check("ovf_set",    32'(ovf),       32'(1'b1));
    check("drop_head",  32'(out_digit), 32'(4'h1));
    out_ready = 1'b1;
    tick(8);
    check("drained",    32'(out_valid), 32'(1'b0));
    check("ovf_sticky", 32'(ovf),       32'(1'b1));

    // Reset mid-count with two entries queued; same pattern as last_acc afterwards is fresh.
    out_ready = 1'b0;
    exp_q.push_back(5'h06);
    seg = seg_tab[6];
    tick(8);
    exp_q.push_back(5'h07);
    seg = seg_tab[7];
    tick(8);
    seg = seg_tab[9];
    tick(3);
    rst_n = 1'b0;
    #1;
    check("pulse_valid", 32'(out_valid), 32'(1'b0));
    check("pulse_digit", 32'(out_digit), 32'(4'h0));
    check("pulse_err",   32'(out_err),   32'(1'b0));
    check("pulse_ovf",   32'(ovf),       32'(1'b0));
    exp_q.delete();
    seg = seg_tab[7];
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(5'h07);
    tick(12);
    check("post_rst_ovf", 32'(ovf), 32'(1'b0));

    // All-zero pattern from reset is still filtered and reported as err.
    rst_n = 1'b0;
    seg   = 7'b0000000;
    tick(2);
    exp_q.delete();
    exp_q.push_back(5'h10);
    rst_n = 1'b1;
    tick(10);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
